// File: rtl/seg_scan_counter.sv
// seg_scan_counter: count-rate prescaler, N-digit BCD up/down counter and a
// time-multiplexed 7-segment scanner with optional leading-zero blanking.
// Segment and digit pins are registered; polarity inversion is applied last.
module seg_scan_counter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int COUNT_HZ    = 1,
  parameter int SCAN_HZ     = 1000,
  parameter int DIGITS      = 4,
  parameter bit BLANK_LZ    = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit DIG_ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  output logic                  tick,
  output logic                  carry,
  output logic [4*DIGITS-1:0]   value,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig
);

  localparam int CNT_DIV  = CLK_HZ / COUNT_HZ;
  localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int PC_W     = $clog2(CNT_DIV);
  localparam int SC_W     = $clog2(SCAN_DIV);
  localparam int IX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW       = 4 * DIGITS;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [VW-1:0]     value_q, value_d;
  logic              tick_q, tick_d;
  logic              carry_q, carry_d;
  logic              step;
  logic              cnt_wrap;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [IX_W-1:0]   idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic [DIGITS-1:0] zero_above;
  logic [3:0]        cur_digit;
  logic              cur_blank;

  // One BCD step with decimal ripple; wrap is set when every digit rolled over.
  function automatic logic [VW-1:0] bcd_step(input logic [VW-1:0] v, input logic inc,
                                              output logic wrap);
    logic [VW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (inc) begin
          if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    wrap = c;
    return r;
  endfunction

  // BCD to active-high {dp,g,f,e,d,c,b,a}; non-decimal codes stay dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Count prescaler and counter next state; clear overrides a coincident step.
  always_comb begin
    step     = en && (pc_q == PC_W'(CNT_DIV - 1));
    pc_d     = pc_q;
    value_d  = value_q;
    tick_d   = 1'b0;
    carry_d  = 1'b0;
    cnt_wrap = 1'b0;
    if (clr) begin
      pc_d    = '0;
      value_d = '0;
    end else if (en) begin
      pc_d = step ? '0 : pc_q + PC_W'(1);
      if (step) begin
        value_d = bcd_step(value_q, up, cnt_wrap);
        tick_d  = 1'b1;
        carry_d = cnt_wrap;
      end
    end
  end

  // Free-running scan prescaler stepping the digit index round-robin.
  always_comb begin
    sc_d  = (sc_q == SC_W'(SCAN_DIV - 1)) ? '0 : sc_q + SC_W'(1);
    idx_d = idx_q;
    if (sc_q == SC_W'(SCAN_DIV - 1))
      idx_d = (idx_q == IX_W'(DIGITS - 1)) ? '0 : idx_q + IX_W'(1);
  end

  // Select the scanned digit, decide blanking, and form the next pin pattern.
  always_comb begin
    logic z;
    z          = 1'b1;
    zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z             = z & (value_q[4*i +: 4] == 4'd0);
      zero_above[i] = z;
    end
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    dig_d     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IX_W'(i)) begin
        cur_digit = value_q[4*i +: 4];
        cur_blank = BLANK_LZ && (i > 0) && zero_above[i];
        dig_d[i]  = 1'b1;
      end
    end
    seg_d = cur_blank ? 8'h00 : seg_decode(cur_digit);
  end

  // State registers; asynchronous active-low reset returns everything to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      value_q <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      sc_q    <= '0;
      idx_q   <= '0;
      seg_q   <= 8'h00;
      dig_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      value_q <= value_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign tick  = tick_q;
  assign carry = carry_q;
  assign value = value_q;
  assign seg   = seg_q ^ {8{SEG_ACT_LOW}};
  assign dig   = dig_q ^ {DIGITS{DIG_ACT_LOW}};

endmodule

// File: tb/tb_seg_scan_counter.sv
module tb_seg_scan_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic up  = 1'b1;
  logic clr = 1'b0;

  logic        tick_a, carry_a, tick_b, carry_b, tick_c, carry_c;
  logic [15:0] value_a, value_b, value_c;
  logic [7:0]  seg_a, seg_b, seg_c;
  logic [3:0]  dig_a, dig_b, dig_c;

  seg_scan_counter #(.CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(5), .DIGITS(4),
    .BLANK_LZ(1'b1), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .tick(tick_a),
    .carry(carry_a), .value(value_a), .seg(seg_a), .dig(dig_a));

  seg_scan_counter #(.CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(5), .DIGITS(4),
    .BLANK_LZ(1'b0), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .tick(tick_b),
    .carry(carry_b), .value(value_b), .seg(seg_b), .dig(dig_b));

  seg_scan_counter #(.CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(5), .DIGITS(4),
    .BLANK_LZ(1'b1), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .tick(tick_c),
    .carry(carry_c), .value(value_c), .seg(seg_c), .dig(dig_c));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic        carry;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model    = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int          t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;  default: return 8'h00;
    endcase
  endfunction

  // Advance the reference counter one step and queue the expected result.
  task automatic model_step(input bit dir);
    exp_t e;
    if (dir) begin
      e.carry = (model == 9999);
      model   = (model + 1) % 10000;
    end else begin
      e.carry = (model == 0);
      model   = (model + 9999) % 10000;
    end
    e.value = to_bcd(model);
    sb.push_back(e);
  endtask

  // Wait (bounded) for the next tick; cyc is the number of edges waited.
  task automatic wait_tick(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (tick_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (seg_a !== 8'h00 || dig_a !== 4'b0000 || value_a !== 16'h0000 ||
          tick_a !== 1'b0 || carry_a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_a: seg=%h dig=%b value=%h tick=%b carry=%b, want 00 0000 0000 0 0",
                 seg_a, dig_a, value_a, tick_a, carry_a);
      end
      n_checks++;
      if (seg_b !== 8'h00 || dig_b !== 4'b0000 || value_b !== 16'h0000 || tick_b !== 1'b0 ||
          carry_b !== 1'b0 || seg_c !== 8'hFF || dig_c !== 4'b1111 || value_c !== 16'h0000 ||
          tick_c !== 1'b0 || carry_c !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_bc: seg_b=%h dig_b=%b seg_c=%h dig_c=%b tick=%b%b carry=%b%b, want 00 0000 FF 1111",
                 seg_b, dig_b, seg_c, dig_c, tick_b, tick_c, carry_b, carry_c);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    exp_t e;
    int   cyc;
    bit   ok;
    en = 1'b1;
    up = 1'b1;
    for (int k = 0; k < 25; k++) begin
      model_step(1'b1);
      wait_tick(cyc, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL count_tick_timeout: step %0d no tick within 40 cycles", k);
      end else if (cyc != 10) begin
        n_fail++;
        $display("FAIL count_interval: step %0d got %0d cycles, want 10", k, cyc);
      end
      n_checks++;
      if (value_a !== e.value || carry_a !== e.carry) begin
        n_fail++;
        $display("FAIL count_value: step %0d got %h/%b, want %h/%b", k, value_a, carry_a,
                 e.value, e.carry);
      end
    end
    n_checks++;
    if (value_a !== 16'h0025) begin
      n_fail++;
      $display("FAIL count_final: got %h, want 0025", value_a);
    end
  endtask

  task automatic test_en_clr();
    exp_t e;
    int   cyc;
    bit   ok;
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (tick_a !== 1'b0 || value_a !== 16'h0025) begin
        n_fail++;
        $display("FAIL en_freeze: cycle %0d tick=%b value=%h, want 0 0025", i, tick_a, value_a);
      end
    end
    en = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr   = 1'b0;
    model = 0;
    n_checks++;
    if (tick_a !== 1'b0 || carry_a !== 1'b0 || value_a !== 16'h0000) begin
      n_fail++;
      $display("FAIL clr_beats_step: tick=%b carry=%b value=%h, want 0 0 0000",
               tick_a, carry_a, value_a);
    end
    model_step(1'b1);
    wait_tick(cyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc != 10 || value_a !== e.value) begin
      n_fail++;
      $display("FAIL clr_restart: ok=%b cyc=%0d value=%h, want 1 10 %h", ok, cyc, value_a, e.value);
    end
    en  = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr   = 1'b0;
    model = 0;
    n_checks++;
    if (value_a !== 16'h0000) begin
      n_fail++;
      $display("FAIL clr_no_en: got %h, want 0000", value_a);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   cyc;
    bit   ok;
    en = 1'b1;
    up = 1'b0;
    model_step(1'b0);
    wait_tick(cyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc != 10 || value_a !== e.value || carry_a !== e.carry) begin
      n_fail++;
      $display("FAIL wrap_down: ok=%b cyc=%0d value=%h carry=%b, want 1 10 %h %b",
               ok, cyc, value_a, carry_a, e.value, e.carry);
    end
    @(posedge clk); #1;
    n_checks++;
    if (carry_a !== 1'b0 || tick_a !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_pulse_len: carry=%b tick=%b, want 0 0", carry_a, tick_a);
    end
    up = 1'b1;
    model_step(1'b1);
    repeat (3) begin @(posedge clk); #1; end
    up = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    up = 1'b1;
    wait_tick(cyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || value_a !== e.value || carry_a !== e.carry) begin
      n_fail++;
      $display("FAIL wrap_up: ok=%b value=%h carry=%b, want 1 %h %b",
               ok, value_a, carry_a, e.value, e.carry);
    end
  endtask

  task automatic test_scan();
    exp_t       e;
    int         cyc;
    bit         ok;
    bit         found;
    logic [3:0] prev;
    logic [3:0] oh;
    logic [7:0] ea [4];
    logic [7:0] eb [4];
    en  = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr   = 1'b0;
    model = 0;
    en    = 1'b1;
    up    = 1'b1;
    for (int k = 0; k < 107; k++) begin
      model_step(1'b1);
      wait_tick(cyc, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || value_a !== e.value) begin
        n_fail++;
        $display("FAIL scan_preload: step %0d ok=%b value=%h, want %h", k, ok, value_a, e.value);
      end
    end
    en = 1'b0;
    ea[0] = seg_code(7); ea[1] = seg_code(0); ea[2] = seg_code(1); ea[3] = 8'h00;
    eb[0] = seg_code(7); eb[1] = seg_code(0); eb[2] = seg_code(1); eb[3] = seg_code(0);
    found = 1'b0;
    prev  = dig_a;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (dig_a == 4'b0001 && prev != 4'b0001) begin
        found = 1'b1;
        break;
      end
      prev = dig_a;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL scan_sync: dig never entered 0001, last dig=%b", dig_a);
    end
    for (int s = 0; s < 8; s++) begin
      oh = 4'b0001 << (s % 4);
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if (dig_a !== oh || seg_a !== ea[s % 4] || dig_b !== oh || seg_b !== eb[s % 4] ||
            dig_c !== ~oh || seg_c !== ~ea[s % 4]) begin
          n_fail++;
          $display("FAIL scan_slot%0d_c%0d: a=%b/%h b=%b/%h c=%b/%h, want %b/%h %b/%h %b/%h",
                   s, c, dig_a, seg_a, dig_b, seg_b, dig_c, seg_c,
                   oh, ea[s % 4], oh, eb[s % 4], ~oh, ~ea[s % 4]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_polarity();
    int cyc;
    bit ok;
    bit found;
    en  = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr   = 1'b0;
    model = 0;
    en    = 1'b1;
    up    = 1'b1;
    for (int k = 0; k < 8; k++) wait_tick(cyc, ok);
    en = 1'b0;
    n_checks++;
    if (value_c !== 16'h0008) begin
      n_fail++;
      $display("FAIL pol_value: got %h, want 0008", value_c);
    end
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (dig_c == 4'b1110) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found || seg_c !== 8'h80 || seg_a !== 8'h7F) begin
      n_fail++;
      $display("FAIL pol_digit0: found=%b seg_c=%h seg_a=%h, want 1 80 7F", found, seg_c, seg_a);
    end
    @(posedge clk); #1;
    while (dig_c == 4'b1110) begin @(posedge clk); #1; end
    n_checks++;
    if (dig_c !== 4'b1101 || seg_c !== 8'hFF) begin
      n_fail++;
      $display("FAIL pol_blank: dig_c=%b seg_c=%h, want 1101 FF", dig_c, seg_c);
    end
    en = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    #2;
    n_checks++;
    if (seg_c !== 8'hFF || dig_c !== 4'b1111 || value_a !== 16'h0000 || seg_a !== 8'h00 ||
        dig_a !== 4'b0000 || tick_a !== 1'b0 || carry_a !== 1'b0) begin
      n_fail++;
      $display("FAIL pol_async_reset: seg_c=%h dig_c=%b value=%h seg_a=%h dig_a=%b, want FF 1111 0000 00 0000",
               seg_c, dig_c, value_a, seg_a, dig_a);
    end
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (dig_a !== 4'b0001 || seg_a !== 8'h3F || tick_a !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_display: dig=%b seg=%h tick=%b, want 0001 3F 0", dig_a, seg_a, tick_a);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_en_clr();
    test_wrap();
    test_scan();
    test_polarity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
